// File: rtl/obstacle_scheduler.sv
// Frame-driven sequencer for the obstacle car slots: advances active slots, retires
// off-screen ones into a random lane, spawns new slots at a fixed frame gap and keeps score.
module obstacle_scheduler #(
    parameter int N_CARS    = 4,
    parameter int LIMIT     = 300,
    parameter int SPAWN_GAP = 60,
    parameter int Y_SPAWN   = 407,
    parameter int LANE_A    = 100,
    parameter int LANE_B    = 300
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              frame_tick,
    input  logic              colision,
    input  logic [1:0]        velocidad,
    input  logic [8:0]        random,
    output logic [N_CARS-1:0] enable,
    output logic [N_CARS-1:0] suma,
    output logic [N_CARS-1:0] salto,
    output logic [8:0]        posicion_x,
    output logic [8:0]        posicion_y,
    output logic [N_CARS-1:0] activo,
    output logic [7:0]        puntaje,
    output logic [1:0]        estado
);

    localparam int IW = (N_CARS > 1) ? $clog2(N_CARS) : 1;

    localparam logic [1:0] EST_IDLE  = 2'd0;
    localparam logic [1:0] EST_RUN   = 2'd1;
    localparam logic [1:0] EST_CRASH = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ADVANCE,
        CHECK,
        CRASH
    } state_t;

    state_t          state;
    logic [8:0]      step [N_CARS];
    logic [7:0]      spawn_timer;
    logic [2:0]      adv_left;
    logic [IW-1:0]   scan;
    logic            spawned;

    logic [IW-1:0]   next_idx;
    logic [8:0]      cnt_eff;
    logic [7:0]      timer_eff;
    logic            spawned_eff;
    logic            act_eff;
    logic            want_salto;
    logic            want_enable;
    logic [8:0]      lane_x;

    // Only the lane-select bit of the LFSR matters here.
    logic            unused_random;
    assign unused_random = ^random[8:1];

    function automatic logic [8:0] sat_inc(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    assign lane_x = random[0] ? 9'(LANE_B) : 9'(LANE_A);

    // Decision for the slot whose pulse is registered at this edge. Outputs are
    // registered, so the next slot is judged with the effects this edge commits.
    always_comb begin
        next_idx    = '0;
        cnt_eff     = step[0];
        timer_eff   = spawn_timer;
        spawned_eff = spawned;
        if (state == ADVANCE) begin
            cnt_eff     = activo[0] ? sat_inc(step[0]) : step[0];
            spawned_eff = 1'b0;
        end else begin
            next_idx    = scan + IW'(1);
            cnt_eff     = step[next_idx];
            if (|enable)
                timer_eff = 8'(SPAWN_GAP);
            spawned_eff = spawned | (|enable);
        end
        act_eff     = activo[next_idx];
        want_salto  = act_eff && (cnt_eff >= 9'(LIMIT));
        want_enable = !act_eff && (timer_eff == 8'd0) && !spawned_eff;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            enable      <= '0;
            suma        <= '0;
            salto       <= '0;
            posicion_x  <= '0;
            posicion_y  <= '0;
            activo      <= '0;
            puntaje     <= '0;
            estado      <= EST_IDLE;
            spawn_timer <= '0;
            adv_left    <= '0;
            scan        <= '0;
            spawned     <= 1'b0;
            for (int i = 0; i < N_CARS; i++)
                step[i] <= '0;
        end else begin
            enable     <= '0;
            suma       <= '0;
            salto      <= '0;
            posicion_x <= '0;
            posicion_y <= '0;
            case (state)
                IDLE: begin
                    if (play) begin
                        state       <= RUN;
                        estado      <= EST_RUN;
                        activo      <= '0;
                        puntaje     <= '0;
                        spawn_timer <= '0;
                        spawned     <= 1'b0;
                        for (int i = 0; i < N_CARS; i++)
                            step[i] <= '0;
                    end
                end
                CRASH: begin
                    if (!play) begin
                        state  <= IDLE;
                        estado <= EST_IDLE;
                    end
                end
                default: begin
                    if (colision) begin
                        state  <= CRASH;
                        estado <= EST_CRASH;
                    end else if (!play) begin
                        state  <= IDLE;
                        estado <= EST_IDLE;
                    end else begin
                        case (state)
                            RUN: begin
                                if (frame_tick) begin
                                    if (spawn_timer != 8'd0)
                                        spawn_timer <= spawn_timer - 8'd1;
                                    adv_left <= 3'(velocidad) + 3'd1;
                                    suma     <= activo;
                                    state    <= ADVANCE;
                                end
                            end
                            ADVANCE: begin
                                for (int i = 0; i < N_CARS; i++)
                                    if (activo[i])
                                        step[i] <= sat_inc(step[i]);
                                if (adv_left == 3'd1) begin
                                    spawned <= 1'b0;
                                    scan    <= '0;
                                    state   <= CHECK;
                                    if (want_salto || want_enable) begin
                                        salto[next_idx]  <= want_salto;
                                        enable[next_idx] <= !want_salto;
                                        posicion_x       <= lane_x;
                                        posicion_y       <= 9'(Y_SPAWN);
                                    end
                                end else begin
                                    adv_left <= adv_left - 3'd1;
                                    suma     <= activo;
                                end
                            end
                            CHECK: begin
                                // Commit the pulse that is ending in this cycle.
                                if (salto[scan]) begin
                                    step[scan] <= '0;
                                    puntaje    <= puntaje + 8'd1;
                                end
                                if (enable[scan]) begin
                                    activo[scan] <= 1'b1;
                                    step[scan]   <= '0;
                                    spawn_timer  <= 8'(SPAWN_GAP);
                                    spawned      <= 1'b1;
                                end
                                if (scan == IW'(N_CARS - 1)) begin
                                    state <= RUN;
                                end else begin
                                    scan <= next_idx;
                                    if (want_salto || want_enable) begin
                                        salto[next_idx]  <= want_salto;
                                        enable[next_idx] <= !want_salto;
                                        posicion_x       <= lane_x;
                                        posicion_y       <= 9'(Y_SPAWN);
                                    end
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Sequencer for the obstacle cars of the game. Owns N_CARS obstacle slots, each a position unit with load/advance/respawn inputs. Once per video frame it issues advance pulses to every active slot, retires slots that have scrolled off-screen by respawning them in a pseudo-random lane, spawns new slots at a fixed frame spacing, and counts passed cars as score. Sits between the frame-tick generator, the LFSR and the bank of car position units.

## Interface
- N_CARS, 4: number of obstacle slots, range 1..8.
- LIMIT, 300: advance pulses before a slot is off-screen, range 1..511.
- SPAWN_GAP, 60: frames between consecutive spawns, range 1..255.
- Y_SPAWN, 407: 9-bit spawn Y, which is -105 in two's complement.
- LANE_A, 100: X for lane A, used when iRandom[0]=0.
- LANE_B, 300: X for lane B, used when iRandom[0]=1.

Ports:
- iClk  in  1  clock; single clock domain.
- iReset  in  1  synchronous, active-high reset.
- iPlay  in  1  game running level.
- iFrameTick  in  1  one-cycle pulse per frame.
- iColision  in  1  player collision, level or pulse.
- iVelocidad  in  2  speed level; advance pulses per frame = iVelocidad+1.
- iRandom  in  9  LFSR value; bit 0 selects lane.
- oEnable  out  N_CARS  one-hot load pulse for a new spawn.
- oSuma  out  N_CARS  advance pulse, one bit per active slot.
- oSalto  out  N_CARS  one-hot respawn pulse.
- oPosicionX  out  9  lane X for the slot being loaded or respawned.
- oPosicionY  out  9  Y_SPAWN while oEnable or oSalto is high, else 0.
- oActivo  out  N_CARS  slot-active flags.
- oPuntaje  out  8  passed-car count; wraps at 255 to 0.
- oEstado  out  2  game state: 0 idle, 1 running, 2 crash.

## Operation
- FSM states: IDLE, RUN, ADVANCE, CHECK, CRASH.
- Per-slot state: 9-bit step counter. Global state: 8-bit spawn timer, advance count k, scan index i, per-frame spawned flag.
- IDLE: all pulses are 0.
  - When iPlay=1, go to RUN.
  - On that transition, clear oActivo, all step counters, oPuntaje, the spawn timer and the spawned flag.
- RUN: wait for iFrameTick.
  - On tick, decrement the spawn timer, saturating at 0.
  - Load k = iVelocidad+1. iVelocidad is sampled only on the tick cycle.
  - Go to ADVANCE.
- ADVANCE: stays k cycles.
  - Each cycle, oSuma = oActivo and every active step counter increments.
  - Then clear the spawned flag, set i=0 and go to CHECK.
- CHECK: one slot per cycle, i = 0..N_CARS-1.
  - If slot i is active and its counter >= LIMIT: pulse oSalto[i], clear the counter and increment oPuntaje.
  - Else if slot i is inactive, the spawn timer is 0 and no spawn has happened this frame: pulse oEnable[i], set oActivo[i], clear the counter, reload the timer to SPAWN_GAP and set the spawned flag.
  - For either pulse, oPosicionX = iRandom[0] ? LANE_B : LANE_A and oPosicionY = Y_SPAWN, both sampled in the same cycle as the pulse.
  - After slot N_CARS-1, go to RUN.
- At most one spawn per frame, always to the lowest-index inactive slot. A respawned slot stays active.
- iColision=1 in RUN, ADVANCE or CHECK: go to CRASH. All pulses are 0 from the next cycle. Counters, flags and score freeze.
- CRASH: ignores ticks. Leaves only when iPlay=0, then goes to IDLE.
- iPlay=0 in RUN, ADVANCE or CHECK: go to IDLE.
- Priority: iReset > iColision > iPlay=0 > iFrameTick.
- iFrameTick in any state other than RUN is dropped and not queued.

## Timing
- All outputs are registered.
- Reset values: every output is 0, and the FSM enters IDLE at the next edge.
- Tick sampled at edge t:
  - oSuma is high for cycles t+1 .. t+k.
  - CHECK covers cycles t+k+1 .. t+k+N_CARS.
  - RUN resumes at t+k+N_CARS+1.
- Minimum tick spacing is k+N_CARS+1 cycles (9 cycles for the defaults at iVelocidad=3).
- oEnable, oSalto and oPosicionX/Y change together, in the same cycle.
- Score and oActivo update on the edge ending the corresponding pulse cycle.
- Reset mid-frame aborts everything. The next cycle has all outputs at 0.

## Test plan
- Reset: iReset for 2 cycles with iPlay=0, then 5 ticks. Required: all outputs 0 and oEstado=0 throughout.
- First spawn: iPlay=1, iVelocidad=0, iRandom=9'h001, tick at t.
  - oSuma=0000 at t+1.
  - oEnable=0001 at t+2 with oPosicionX=300 and oPosicionY=407.
  - oActivo=0001 afterwards.
  - The next spawn (oEnable=0010) comes exactly 60 ticks later.
- Retire (LIMIT=4, iVelocidad=3, slot 0 active with counter 0): one tick.
  - oSuma[0] is high for 4 cycles.
  - oSalto[0] pulses in the following cycle with oPosicionX=100 when iRandom[0]=0.
  - oPuntaje goes 0 to 1.
- Collision: iColision pulse during the 2nd ADVANCE cycle.
  - oSuma=0 from the next cycle and oEstado=2; ticks are ignored.
  - iPlay=0 gives oEstado=0.
  - iPlay=1 then clears oActivo and oPuntaje.
- Dropped tick: ticks at t and t+3 with N_CARS=4, k=1. Required: exactly one oSuma burst and one CHECK scan.
- Score wrap: 256 retirements. Required: oPuntaje goes 255 to 0 with no other side effect.
